// File: rtl/gray_to_binary_tracker_if.sv
// Sample/result bundle between a Gray pointer source and the Gray-to-binary tracker.
interface gray_to_binary_tracker_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic [WIDTH-1:0] gray_in;
  logic             in_valid;
  logic [WIDTH-1:0] binary_out;
  logic             out_valid;
  logic             step_up;
  logic             step_down;
  logic             wrap;
  logic             step_err;
  logic [7:0]       err_count;

  modport master (
    output gray_in, in_valid,
    input  binary_out, out_valid, step_up, step_down, wrap, step_err, err_count
  );

  modport slave (
    input  gray_in, in_valid,
    output binary_out, out_valid, step_up, step_down, wrap, step_err, err_count
  );
endinterface

// File: rtl/gray_to_binary_tracker.sv
// Two-stage Gray-to-binary decoder that classifies each sample against the previous one
// as hold, +1, -1 (with wrap) or an illegal jump, and counts illegal jumps.
module gray_to_binary_tracker #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  gray_to_binary_tracker_if.slave  bus
);

  typedef enum logic [1:0] {StInit, StTrack, StResync} state_e;

  localparam logic [WIDTH-1:0] MaxVal = '1;
  localparam logic [WIDTH-1:0] One    = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] s1_gray_q, s1_gray_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] prev_bin_q, prev_bin_d;
  logic [WIDTH-1:0] binary_out_q, binary_out_d;
  logic             out_valid_q, out_valid_d;
  logic             step_up_q, step_up_d;
  logic             step_down_q, step_down_d;
  logic             wrap_q, wrap_d;
  logic             step_err_q, step_err_d;
  logic [7:0]       err_count_q, err_count_d;

  logic [WIDTH-1:0] s1_bin;
  logic [WIDTH-1:0] diff;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    s1_bin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      s1_bin[i] = ^(s1_gray_q >> i);
    end
  end

  assign diff = s1_bin - prev_bin_q;

  always_comb begin
    s1_gray_d    = bus.gray_in;
    s1_valid_d   = bus.in_valid;
    state_d      = state_q;
    prev_bin_d   = prev_bin_q;
    binary_out_d = binary_out_q;
    out_valid_d  = 1'b0;
    step_up_d    = 1'b0;
    step_down_d  = 1'b0;
    wrap_d       = 1'b0;
    step_err_d   = 1'b0;
    err_count_d  = err_count_q;

    if (s1_valid_q) begin
      out_valid_d  = 1'b1;
      binary_out_d = s1_bin;
      prev_bin_d   = s1_bin;
      case (state_q)
        StInit, StResync: state_d = StTrack;
        StTrack: begin
          if (diff == '0) begin
            state_d = StTrack;
          end else if (diff == One) begin
            step_up_d = 1'b1;
            wrap_d    = (prev_bin_q == MaxVal);
          end else if (diff == MaxVal) begin
            step_down_d = 1'b1;
            wrap_d      = (prev_bin_q == '0);
          end else begin
            step_err_d = 1'b1;
            state_d    = StResync;
            if (err_count_q != 8'hFF) begin
              err_count_d = err_count_q + 8'd1;
            end
          end
        end
        default: state_d = StInit;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StInit;
      s1_gray_q    <= '0;
      s1_valid_q   <= 1'b0;
      prev_bin_q   <= '0;
      binary_out_q <= '0;
      out_valid_q  <= 1'b0;
      step_up_q    <= 1'b0;
      step_down_q  <= 1'b0;
      wrap_q       <= 1'b0;
      step_err_q   <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      s1_gray_q    <= s1_gray_d;
      s1_valid_q   <= s1_valid_d;
      prev_bin_q   <= prev_bin_d;
      binary_out_q <= binary_out_d;
      out_valid_q  <= out_valid_d;
      step_up_q    <= step_up_d;
      step_down_q  <= step_down_d;
      wrap_q       <= wrap_d;
      step_err_q   <= step_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.binary_out = binary_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.step_up    = step_up_q;
  assign bus.step_down  = step_down_q;
  assign bus.wrap       = wrap_q;
  assign bus.step_err   = step_err_q;
  assign bus.err_count  = err_count_q;

endmodule

// File: doc/gray_to_binary_tracker.md
# gray_to_binary_tracker

Registered Gray-to-binary decoder and step tracker for Gray-coded counters and pointers, the receive-side counterpart of the team's binary-to-Gray converter. It accepts Gray-coded samples (e.g. a pointer already synchronized into this clock domain) and produces the binary value. It also checks every sample against the previous accepted one and reports up, down and wrap steps plus illegal jumps. It sits between a pointer synchronizer and FIFO full/empty or occupancy logic.

## Interface
- WIDTH, 4, bit width of the Gray input and the binary output (2..16)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- gray_in  input  WIDTH  Gray-coded sample
- in_valid  input  1  gray_in is sampled on this clock edge
- binary_out  output  WIDTH  decoded binary value
- out_valid  output  1  one-cycle strobe; binary_out and the flags below are valid
- step_up  output  1  sample = previous + 1 (mod 2^WIDTH)
- step_down  output  1  sample = previous - 1 (mod 2^WIDTH)
- wrap  output  1  step crossed the boundary: max→0 going up, or 0→max going down
- step_err  output  1  sample differs from previous by more than ±1 (mod 2^WIDTH)
- err_count  output  8  saturating count of step_err events

## Operation
- Stage 1 registers gray_in into s1_gray and in_valid into s1_valid.
- Conversion:
  - b[WIDTH-1] = g[WIDTH-1].
  - b[i] = b[i+1] ^ g[i], for i descending.
  - Combinational on s1_gray; registered into binary_out in stage 2.
- Reference register prev_bin holds the last accepted binary value.
- Difference d = (new − prev_bin) mod 2^WIDTH, in WIDTH-bit wrap-around arithmetic.
- FSM states:
  - INIT (entered from reset): the first valid sample loads prev_bin. No check; out_valid=1, all flags 0. Go to TRACK.
  - TRACK, on each valid sample:
    - d=0 → hold; no flags.
    - d=1 → step_up. Also wrap if prev_bin = 2^WIDTH−1.
    - d=2^WIDTH−1 → step_down. Also wrap if prev_bin = 0.
    - any other d → step_err=1; err_count += 1, saturating at 255; go to RESYNC.
    - prev_bin is updated in every case, including on error.
  - RESYNC: the next valid sample is handled like INIT (loads prev_bin, no check, flags 0). Go to TRACK.
- A single-bit Gray change that does not map to ±1 in binary is an error. Example: Gray 0000→0100 is binary 0→7.
- step_up, step_down and step_err are mutually exclusive. wrap is only ever set together with step_up or step_down.
- Cycles with in_valid=0 do not touch prev_bin or the FSM.

## Timing
- Latency is 2 cycles. A sample taken on edge N appears with out_valid=1 after edge N+1 and holds for exactly one cycle.
- Flags and err_count are registered and change on the same edge as out_valid.
- Flags are 0 whenever out_valid=0.
- binary_out holds its last value while out_valid=0.
- Back-to-back in_valid gives one result per cycle, with no bubbles and no backpressure.
- Reset values: binary_out=0, out_valid=0, step_up=0, step_down=0, wrap=0, step_err=0, err_count=0, FSM=INIT, prev_bin=0, s1_valid=0.
- Reset asserted mid-stream:
  - A sample in flight in stage 1 is discarded and produces no out_valid.
  - The first valid sample after reset is an INIT load.
- rst has priority over in_valid on the same edge.

## Test plan (WIDTH=4)
- Exhaustive decode: drive all 16 Gray codes back-to-back. binary_out must equal the reference decode, out_valid must follow in_valid delayed by 2 cycles, and every check after the first must be checked against its ±1/error rule.
- Up count: Gray 0000,0001,0011,0010 → binary 0,1,2,3. First sample has no flags; then step_up=1 three times; err_count=0.
- Wrap both ways:
  - Gray 1000 (15) → 0000 (0): step_up=1, wrap=1.
  - Then 0000 → 1000: step_down=1, wrap=1.
- Hold and gaps: repeat Gray 0011 with in_valid toggling 1,0,1. Expect one out_valid per valid sample with binary_out=2 and no flags; binary_out holds during the gap.
- Illegal jump and resync:
  - Gray 0000 → 0100 gives binary 7, step_err=1, err_count=1.
  - The next sample, 1100 (8), has no flags (RESYNC).
  - Then 1101 (9) gives step_up=1.
  - Force 300 errors: err_count saturates at 255.
- Reset mid-stream: assert rst one cycle after a valid sample. That sample produces no out_valid, and all outputs are 0. The next sample is treated as INIT (no flags).
